// File: rtl/matrix_scan_ctrl.sv
// Column scanner for an 8x7 LED matrix driven through a 1-to-8 active-low demux.
// A frame is latched once per scan and each column dwells, then blanks, in turn.
//
// state | meaning
// IDLE  | scan stopped, all columns off, waiting for en
// LOAD  | one cycle, frame_in latched into the frame buffer
// ON    | column input_sel driven for ON_CYC cycles
// BLANK | all columns off for BLANK_CYC cycles before the next column
module matrix_scan_ctrl #(
   parameter int unsigned ON_CYC    = 1000,
   parameter int unsigned BLANK_CYC = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [55:0] frame_in,
   output logic        A,
   output logic [2:0]  input_sel,
   output logic [6:0]  row_out,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [15:0] ON_LD    = 16'(ON_CYC - 1);
   localparam logic [15:0] BLANK_LD = 16'(BLANK_CYC - 1);

   typedef enum logic [1:0] {IDLE, LOAD, ON, BLANK} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  sel_q, sel_d;
   logic [55:0] buf_q, buf_d;
   logic        a_q, a_d;
   logic [6:0]  row_q, row_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Dwell timer counts down to zero; terminal count ends the state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      buf_d   = buf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            sel_d = 3'd0;
            if (en) begin
               state_d = LOAD;
               cnt_d   = 16'd0;
            end
         end
         LOAD: begin
            buf_d   = frame_in;
            sel_d   = 3'd0;
            state_d = ON;
            cnt_d   = ON_LD;
         end
         ON: begin
            if (cnt_q == 16'd0) begin
               state_d = BLANK;
               cnt_d   = BLANK_LD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         BLANK: begin
            if (cnt_q == 16'd0) begin
               if (sel_q == 3'd7) begin
                  sel_d   = 3'd0;
                  done_d  = 1'b1;
                  state_d = en ? LOAD : IDLE;
                  cnt_d   = 16'd0;
               end else begin
                  sel_d   = sel_q + 3'd1;
                  state_d = ON;
                  cnt_d   = ON_LD;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            sel_d   = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_comb begin
      a_d    = (state_d != ON);
      busy_d = (state_d != IDLE);
      row_d  = 7'd0;
      if (state_d == ON) begin
         for (int c = 0; c < 8; c++) begin
            if (sel_d == 3'(c)) row_d = buf_d[7*c +: 7];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         sel_q   <= 3'd0;
         buf_q   <= 56'd0;
         a_q     <= 1'b1;
         row_q   <= 7'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         buf_q   <= buf_d;
         a_q     <= a_d;
         row_q   <= row_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign A          = a_q;
   assign input_sel  = sel_q;
   assign row_out    = row_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: directed vector table, hand-written corner
// sequences and random en/frame traffic against a frame-offset reference model.
module tb_matrix_scan_ctrl;

   localparam int ON_CYC    = 4;
   localparam int BLANK_CYC = 2;
   localparam int COL_LEN   = ON_CYC + BLANK_CYC;
   localparam int FRAME_LEN = 1 + 8 * COL_LEN;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [55:0] frame_in;
   logic        A;
   logic [2:0]  input_sel;
   logic [6:0]  row_out;
   logic        busy;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   matrix_scan_ctrl #(.ON_CYC(ON_CYC), .BLANK_CYC(BLANK_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .frame_in   (frame_in),
      .A          (A),
      .input_sel  (input_sel),
      .row_out    (row_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: position k within a frame, k=0 is the load cycle.
   bit          m_active;
   int          m_k;
   logic [55:0] m_buf;
   bit          m_done;

   task automatic model_reset();
      m_active = 0;
      m_k      = 0;
      m_buf    = '0;
      m_done   = 0;
   endtask

   task automatic model_step();
      m_done = 0;
      if (!m_active) begin
         if (en) begin
            m_active = 1;
            m_k      = 0;
         end
      end else if (m_k == FRAME_LEN - 1) begin
         m_done = 1;
         if (en) m_k = 0;
         else    m_active = 0;
      end else begin
         if (m_k == 0) m_buf = frame_in;
         m_k++;
      end
   endtask

   function automatic logic [12:0] model_out();
      int   j, col;
      bit   on;
      logic [6:0] r;
      if (!m_active) return {1'b1, 3'd0, 7'd0, 1'b0, m_done};
      if (m_k == 0)  return {1'b1, 3'd0, 7'd0, 1'b1, m_done};
      j   = m_k - 1;
      col = j / COL_LEN;
      on  = (j % COL_LEN) < ON_CYC;
      r   = on ? m_buf[7*col +: 7] : 7'd0;
      return {~on, 3'(col), r, 1'b1, m_done};
   endfunction

   function automatic logic [12:0] dut_out();
      return {A, input_sel, row_out, busy, frame_done};
   endfunction

   task automatic compare(input string tag, input logic [12:0] exp);
      logic [12:0] got;
      got = dut_out();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got A=%b sel=%0d row=%h busy=%b done=%b, want A=%b sel=%0d row=%h busy=%b done=%b",
                  tag, $time, got[12], got[11:9], got[8:2], got[1], got[0],
                  exp[12], exp[11:9], exp[8:2], exp[1], exp[0]);
      end
   endtask

   task automatic expect_out(input string tag, input logic a, input logic [2:0] s,
                             input logic [6:0] r, input logic b, input logic d);
      compare(tag, {a, s, r, b, d});
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare(tag, model_out());
   endtask

   // Called just after a falling edge; reset lands between clock edges.
   task automatic async_reset(input string tag);
      #3 rst_n = 1'b0;
      #1 expect_out(tag, 1'b1, 3'd0, 7'd0, 1'b0, 1'b0);
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Invariants: select stable while a column is driven, no stretched frame_done.
   logic prev_valid = 1'b0;
   logic prev_a, prev_done;
   logic [2:0] prev_sel;
   always @(negedge clk) begin
      if (rst_n && prev_valid) begin
         if (!prev_a && !A) begin
            n_checks++;
            if (input_sel !== prev_sel) begin
               n_fail++;
               $display("FAIL sel_stable t=%0t got sel=%0d, want sel=%0d", $time, input_sel, prev_sel);
            end
         end
         if (prev_done) begin
            n_checks++;
            if (frame_done !== 1'b0) begin
               n_fail++;
               $display("FAIL done_single t=%0t got frame_done=%b on two cycles, want 0", $time, frame_done);
            end
         end
      end
      prev_valid = rst_n;
      prev_a     = A;
      prev_sel   = input_sel;
      prev_done  = frame_done;
   end

   typedef struct {
      int         n;
      logic       a;
      logic [2:0] sel;
      logic [6:0] row;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[18];

   function automatic logic [55:0] walk_pattern();
      logic [55:0] f;
      logic [6:0]  one;
      f   = '0;
      one = 7'h01;
      for (int c = 0; c < 8; c++) f[7*c +: 7] = one << (c % 7);
      return f;
   endfunction

   task automatic drain(input string tag);
      for (int i = 0; i < 60; i++) begin
         if (!busy) break;
         tick(tag);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_timeout got busy=%b, want 0", tag, busy);
      end
   endtask

   initial begin
      int ti, pulses;
      bit saw_col7;
      logic [63:0] rnd;

      tbl[0]  = '{1,  1'b1, 3'd0, 7'h00, 1'b1, 1'b0};
      tbl[1]  = '{2,  1'b0, 3'd0, 7'h01, 1'b1, 1'b0};
      tbl[2]  = '{5,  1'b0, 3'd0, 7'h01, 1'b1, 1'b0};
      tbl[3]  = '{6,  1'b1, 3'd0, 7'h00, 1'b1, 1'b0};
      tbl[4]  = '{7,  1'b1, 3'd0, 7'h00, 1'b1, 1'b0};
      tbl[5]  = '{8,  1'b0, 3'd1, 7'h02, 1'b1, 1'b0};
      tbl[6]  = '{14, 1'b0, 3'd2, 7'h04, 1'b1, 1'b0};
      tbl[7]  = '{19, 1'b1, 3'd2, 7'h00, 1'b1, 1'b0};
      tbl[8]  = '{20, 1'b0, 3'd3, 7'h08, 1'b1, 1'b0};
      tbl[9]  = '{26, 1'b0, 3'd4, 7'h10, 1'b1, 1'b0};
      tbl[10] = '{33, 1'b0, 3'd5, 7'h20, 1'b1, 1'b0};
      tbl[11] = '{38, 1'b0, 3'd6, 7'h40, 1'b1, 1'b0};
      tbl[12] = '{44, 1'b0, 3'd7, 7'h01, 1'b1, 1'b0};
      tbl[13] = '{47, 1'b0, 3'd7, 7'h01, 1'b1, 1'b0};
      tbl[14] = '{49, 1'b1, 3'd7, 7'h00, 1'b1, 1'b0};
      tbl[15] = '{50, 1'b1, 3'd0, 7'h00, 1'b1, 1'b1};
      tbl[16] = '{51, 1'b0, 3'd0, 7'h01, 1'b1, 1'b0};
      tbl[17] = '{99, 1'b1, 3'd0, 7'h00, 1'b1, 1'b1};

      rst_n    = 1'b0;
      en       = 1'b0;
      frame_in = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      expect_out("reset_state", 1'b1, 3'd0, 7'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;

      // Idle with en low
      for (int i = 0; i < 20; i++) begin
         tick("idle_en0");
         expect_out("idle_hold", 1'b1, 3'd0, 7'd0, 1'b0, 1'b0);
      end

      // Directed walking-bit frames against the vector table
      frame_in = walk_pattern();
      en       = 1'b1;
      ti       = 0;
      pulses   = 0;
      for (int n = 1; n <= 99; n++) begin
         tick("scan_model");
         if (frame_done) pulses++;
         if (ti < 18 && tbl[ti].n == n) begin
            expect_out($sformatf("scan_vec_n%0d", n), tbl[ti].a, tbl[ti].sel,
                       tbl[ti].row, tbl[ti].busy, tbl[ti].done);
            ti++;
         end
      end
      n_checks++;
      if (pulses != 2) begin
         n_fail++;
         $display("FAIL done_period got %0d pulses, want 2", pulses);
      end
      en = 1'b0;
      drain("drain1");

      // frame_in change during column 3 must not disturb the frame in flight
      frame_in = walk_pattern();
      en       = 1'b1;
      for (int n = 1; n <= 99; n++) begin
         tick("latch_model");
         if (n == 21) frame_in = {56{1'b1}};
         if (n == 26) expect_out("latch_old_c4", 1'b0, 3'd4, 7'h10, 1'b1, 1'b0);
         if (n == 44) expect_out("latch_old_c7", 1'b0, 3'd7, 7'h01, 1'b1, 1'b0);
         if (n == 51) expect_out("latch_new_c0", 1'b0, 3'd0, 7'h7F, 1'b1, 1'b0);
         if (n == 81) expect_out("latch_new_c5", 1'b0, 3'd5, 7'h7F, 1'b1, 1'b0);
      end
      en = 1'b0;
      drain("drain2");

      // en dropped during column 2: frame still completes, then IDLE
      frame_in = walk_pattern();
      en       = 1'b1;
      pulses   = 0;
      saw_col7 = 0;
      for (int n = 1; n <= 60; n++) begin
         tick("drop_model");
         if (frame_done) pulses++;
         if (!A && input_sel == 3'd7) saw_col7 = 1;
         if (n == 15) en = 1'b0;
         if (n == 50) expect_out("drop_end", 1'b1, 3'd0, 7'h00, 1'b0, 1'b1);
         if (n == 60) expect_out("drop_idle", 1'b1, 3'd0, 7'h00, 1'b0, 1'b0);
      end
      n_checks++;
      if (pulses != 1 || !saw_col7) begin
         n_fail++;
         $display("FAIL drop_frame got pulses=%0d col7_seen=%0d, want pulses=1 col7_seen=1", pulses, saw_col7);
      end

      // Asynchronous reset in the middle of column 5
      frame_in = walk_pattern();
      en       = 1'b1;
      for (int n = 1; n <= 33; n++) tick("rst_pre");
      expect_out("rst_pre_c5", 1'b0, 3'd5, 7'h20, 1'b1, 1'b0);
      en = 1'b0;
      async_reset("rst_async");
      for (int i = 0; i < 10; i++) tick("rst_idle");

      // Random en / frame traffic with occasional reset
      for (int i = 0; i < 4000; i++) begin
         tick("random");
         if ($urandom_range(0, 29) == 0) en = ~en;
         if ($urandom_range(0, 3) == 0) begin
            rnd      = {$urandom(), $urandom()};
            frame_in = rnd[55:0];
         end
         if ($urandom_range(0, 999) == 0) async_reset("rand_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
